// File: rtl/segment_pkg.sv
// rtl/segment_pkg.sv - glyph table, FSM states and strobe helpers shared by segment_readback
package segment_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-low glyphs (bit6=g .. bit0=a), listed F down to 0 so GLYPH_TABLE[i] draws digit i
  localparam logic [15:0][6:0] GLYPH_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0011000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE,
    ST_HOLD
  } state_t;

  function automatic logic strobe_valid(input logic [3:0] dig_n);
    return $countones(~dig_n) == 1;
  endfunction

  function automatic logic [1:0] strobe_index(input logic [3:0] dig_n);
    case (dig_n)
      4'b1110: return 2'd0;
      4'b1101: return 2'd1;
      4'b1011: return 2'd2;
      4'b0111: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg_to_hex.sv
// rtl/seg_to_hex.sv - reverse glyph lookup: active-low segment pattern to hex nibble
module seg_to_hex
  import segment_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Glyphs are unique, so at most one entry can match
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == GLYPH_TABLE[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/segment_readback.sv
// rtl/segment_readback.sv - rebuilds the 16-bit word from the scanned 4-digit display bus
// Optional SEGMENT_READBACK_COMPARE_EN adds an expected-word compare with a mismatch flag.
module segment_readback
  import segment_pkg::*;
#(
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  dig_n,
  output logic [15:0] word_out,
  output logic        word_err,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        timeout_err
`ifdef SEGMENT_READBACK_COMPARE_EN
  ,
  input  logic [15:0] expect_word,
  input  logic [15:0] compare_mask,
  output logic        mismatch
`endif
);

  localparam int         TW          = $clog2(TIMEOUT);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t                    state_q, state_d;
  logic [3:0]                cur_dig_q, cur_dig_d;
  logic [7:0]                settle_cnt_q, settle_cnt_d;
  logic [NUM_DIGITS-1:0]     seen_q, seen_cap;
  logic [4*NUM_DIGITS-1:0]   nibs_q, nibs_cap;
  logic                      err_acc_q, err_cap;
  logic [TW-1:0]             tmo_cnt_q;
  logic                      capture, strobe_ok;
  logic [1:0]                cap_idx;
  logic [3:0]                dec_nibble;
  logic                      dec_illegal;
  logic                      complete, accept, frame_part, tmo_hit;

  seg_to_hex u_seg_to_hex (
    .seg     (seg_in),
    .nibble  (dec_nibble),
    .illegal (dec_illegal)
  );

  assign strobe_ok = strobe_valid(dig_n);
  assign cap_idx   = strobe_index(cur_dig_q);

  // HOLD and SETTLE both react to a strobe change by restarting on the new digit
  always_comb begin
    state_d      = state_q;
    cur_dig_d    = cur_dig_q;
    settle_cnt_d = settle_cnt_q;
    capture      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (strobe_ok) begin
          state_d      = ST_SETTLE;
          cur_dig_d    = dig_n;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE, ST_HOLD: begin
        if (dig_n != cur_dig_q) begin
          if (strobe_ok) begin
            state_d      = ST_SETTLE;
            cur_dig_d    = dig_n;
            settle_cnt_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (state_q == ST_SETTLE) begin
          if (settle_cnt_q == SETTLE_LAST) state_d = ST_CAPTURE;
          else                             settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_CAPTURE: begin
        capture = 1'b1;
        state_d = ST_HOLD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    seen_cap = seen_q;
    nibs_cap = nibs_q;
    err_cap  = err_acc_q;
    if (capture) begin
      seen_cap[cap_idx]                = 1'b1;
      nibs_cap[{cap_idx, 2'b00} +: 4]  = dec_nibble;
      err_cap                          = err_acc_q | dec_illegal;
    end
  end

  // Completion looks at the post-capture view so the word appears one clock after CAPTURE
  assign complete   = (seen_cap == '1) && !word_valid;
  assign accept     = word_valid && word_ready;
  assign frame_part = (seen_q != '0) && (seen_q != '1);
  assign tmo_hit    = frame_part && (tmo_cnt_q == TMO_LAST) && !complete;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cur_dig_q    <= 4'hF;
      settle_cnt_q <= '0;
      seen_q       <= '0;
      nibs_q       <= '0;
      err_acc_q    <= 1'b0;
      tmo_cnt_q    <= '0;
      word_out     <= '0;
      word_err     <= 1'b0;
      word_valid   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_dig_q    <= cur_dig_d;
      settle_cnt_q <= settle_cnt_d;
      nibs_q       <= nibs_cap;
      timeout_err  <= 1'b0;
      if (accept) word_valid <= 1'b0;
      if (complete) begin
        word_out   <= nibs_cap;
        word_err   <= err_cap;
        word_valid <= 1'b1;
        seen_q     <= '0;
        err_acc_q  <= 1'b0;
        tmo_cnt_q  <= '0;
      end else if (tmo_hit) begin
        seen_q      <= '0;
        err_acc_q   <= 1'b0;
        tmo_cnt_q   <= '0;
        timeout_err <= 1'b1;
      end else begin
        seen_q    <= seen_cap;
        err_acc_q <= err_cap;
        tmo_cnt_q <= frame_part ? tmo_cnt_q + 1'b1 : '0;
      end
    end
  end

`ifdef SEGMENT_READBACK_COMPARE_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mismatch <= 1'b0;
    end else if (complete) begin
      mismatch <= (|((nibs_cap ^ expect_word) & compare_mask)) | err_cap;
    end else if (accept) begin
      mismatch <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_segment_readback.sv
// tb/tb_segment_readback.sv - scoreboard bench for segment_readback (SEGMENT_READBACK_COMPARE_EN aware)
module tb_segment_readback;

  localparam int SETTLE  = 4;
  localparam int TIMEOUT = 64;
  localparam int CAP_MIN = SETTLE + 2;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [6:0]  seg_in  = 7'h7F;
  logic [3:0]  dig_n   = 4'hF;
  logic        word_ready = 1'b1;
  logic [15:0] word_out;
  logic        word_err, word_valid, timeout_err;
  logic [15:0] expect_word  = 16'h0;
  logic [15:0] compare_mask = 16'h0;
`ifdef SEGMENT_READBACK_COMPARE_EN
  logic        mismatch;
`endif

  segment_readback #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .seg_in       (seg_in),
    .dig_n        (dig_n),
    .word_out     (word_out),
    .word_err     (word_err),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .timeout_err  (timeout_err)
`ifdef SEGMENT_READBACK_COMPARE_EN
    ,
    .expect_word  (expect_word),
    .compare_mask (compare_mask),
    .mismatch     (mismatch)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  logic [3:0] bad_strobes [5] = '{4'b0000, 4'b1001, 4'b0011, 4'b1100, 4'b0101};

  typedef struct {
    logic [15:0] word;
    logic        err;
    logic        mm;
  } exp_t;

  exp_t       expq [$];
  logic [3:0] m_seen = 4'h0;
  logic [3:0] m_nib [4];
  logic       m_err = 1'b0;

  function automatic logic is_glyph(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (glyph[i] == p) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [6:0] bad_pattern();
    logic [6:0] p;
    do p = 7'($urandom); while (is_glyph(p));
    return p;
  endfunction

  function automatic logic [3:0] dn_of(input int idx);
    logic [3:0] one = 4'b0001;
    return ~(one << idx);
  endfunction

  // Frame model: a word is owed once every digit has been captured since the last word
  task automatic model_capture(input int idx, input logic [3:0] nib, input logic ill);
    exp_t e;
    m_nib[idx]  = nib;
    m_seen[idx] = 1'b1;
    m_err       = m_err | ill;
    if (m_seen == 4'hF) begin
      e.word = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
      e.err  = m_err;
      e.mm   = (|((e.word ^ expect_word) & compare_mask)) | m_err;
      expq.push_back(e);
      m_seen = 4'h0;
      m_err  = 1'b0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  logic [3:0] last_dn = 4'hF;
  int         last_strobe_cyc = 0;

  // Back-to-back strobes of one digit look continuous, so split them with a blank
  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    if (d == last_dn && $countones(~d) == 1) begin
      dig_n = 4'hF;
      tick(1);
    end
    dig_n = d;
    seg_in = s;
    last_dn = d;
    last_strobe_cyc = cyc;
    tick(n);
  endtask

  task automatic blank(input int n);
    drive(4'hF, 7'h7F, n);
  endtask

  task automatic cap_raw(input int idx, input logic [6:0] pat, input logic [3:0] nib,
                         input logic ill, input int n);
    model_capture(idx, nib, ill);
    drive(dn_of(idx), pat, n);
  endtask

  task automatic cap(input int idx, input logic [3:0] v, input int n);
    cap_raw(idx, glyph[v], v, 1'b0, n);
  endtask

  task automatic cap_bad(input int idx, input int n);
    cap_raw(idx, bad_pattern(), 4'h0, 1'b1, n);
  endtask

  task automatic glitch(input int idx, input int n);
    drive(dn_of(idx), glyph[$urandom_range(15)], n);
  endtask

  task automatic scan_word(input logic [15:0] w, input int n);
    cap(3, w[15:12], n);
    cap(2, w[11:8], n);
    cap(1, w[7:4], n);
    cap(0, w[3:0], n);
  endtask

  logic        lat_chk = 1'b0;
  logic        tmo_ok  = 1'b0;
  int          tmo_pulses = 0;

  initial begin
    logic        prev_valid = 1'b0;
    logic        prev_acc   = 1'b0;
    logic        prev_tmo   = 1'b0;
    logic        prev_err   = 1'b0;
    logic [15:0] prev_word  = 16'h0;
    exp_t        e;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        if (word_valid && !prev_valid && lat_chk)
          check("capture_to_valid_latency", cyc - last_strobe_cyc, SETTLE + 2);
        if (prev_valid && !prev_acc) begin
          check("valid_held_until_accept", word_valid, 1'b1);
          if (word_valid) begin
            check("word_out_stable", word_out, prev_word);
            check("word_err_stable", word_err, prev_err);
          end
        end
        if (word_valid && word_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word actual=%h required=no_word", word_out);
          end else begin
            e = expq.pop_front();
            check("word_out", word_out, e.word);
            check("word_err", word_err, e.err);
`ifdef SEGMENT_READBACK_COMPARE_EN
            check("mismatch", mismatch, e.mm);
`endif
          end
        end
        if (timeout_err) begin
          tmo_pulses++;
          check("timeout_allowed", tmo_ok, 1'b1);
          check("timeout_single_cycle", prev_tmo, 1'b0);
        end
      end
      prev_valid = word_valid;
      prev_acc   = word_valid && word_ready;
      prev_tmo   = timeout_err;
      prev_word  = word_out;
      prev_err   = word_err;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int idx;
    int recaps;
    logic done;

    tick(3);
    check("reset_word_out", word_out, 16'h0);
    check("reset_word_valid", word_valid, 1'b0);
    check("reset_word_err", word_err, 1'b0);
    check("reset_timeout_err", timeout_err, 1'b0);
    reset_n = 1'b1;
    blank(3);

    // 1234 twice with 8-cycle strobes, one word per frame
    lat_chk = 1'b1;
    scan_word(16'h1234, 8);
    scan_word(16'h1234, 8);
    blank(4);
    lat_chk = 1'b0;

    // ABCD scan with digit 2 blank
    cap(3, 4'hA, 8);
    cap_raw(2, 7'b1111111, 4'h0, 1'b1, 8);
    cap(1, 4'hC, 8);
    cap(0, 4'hD, 8);
    blank(4);

    // Digit 2 strobed 3 cycles only: no capture until a full-length strobe
    cap(3, 4'h5, 8);
    glitch(2, 3);
    cap(1, 4'h7, 8);
    cap(0, 4'h8, 8);
    cap(2, 4'h6, 8);
    blank(4);

    // Consumer stalls while 00FF then 1111 are scanned
    word_ready = 1'b0;
    scan_word(16'h00FF, 8);
    scan_word(16'h1111, 8);
    blank(10);
    word_ready = 1'b1;
    @(negedge clock);
    check("stall_accept_valid", word_valid, 1'b1);
    @(negedge clock);
    check("stall_gap_valid", word_valid, 1'b0);
    @(negedge clock);
    check("stall_reload_valid", word_valid, 1'b1);
    check("stall_reload_word", word_out, 16'h1111);
    tick(1);
    blank(4);

    // Only digits 0 and 1 strobe, with illegal and blank strobes between
    tmo_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(4'b1110, glyph[$urandom_range(15)], 8);
      drive(4'b1001, glyph[$urandom_range(15)], 3);
      drive(4'b1101, glyph[$urandom_range(15)], 8);
      drive(4'b1111, 7'h7F, 2);
    end
    blank(TIMEOUT + 8);
    tmo_ok = 1'b0;
    check("timeout_pulse_seen", tmo_pulses > 0, 1'b1);

    // Reset after three digits, then rescan starting from digit 0
    cap(3, 4'h1, 8);
    cap(2, 4'h2, 8);
    cap(1, 4'h3, 8);
    blank(2);
    reset_n = 1'b0;
    m_seen = 4'h0;
    m_err = 1'b0;
    tick(2);
    check("midreset_word_valid", word_valid, 1'b0);
    check("midreset_word_out", word_out, 16'h0);
    reset_n = 1'b1;
    blank(2);
    expect_word = 16'h9A5F;
    compare_mask = 16'hFFFF;
    cap(0, 4'hE, 8);
    cap(1, 4'h5, 8);
    cap(2, 4'hA, 8);
    cap(3, 4'h9, 8);
    blank(4);

    // Randomised frames with glitches, recaptures and illegal glyphs
    for (int f = 0; f < 30; f++) begin
      expect_word  = 16'($urandom);
      compare_mask = ($urandom_range(1) == 1) ? 16'hFFFF : 16'($urandom);
      if ($urandom_range(3) == 0)
        drive(bad_strobes[$urandom_range(4)], glyph[$urandom_range(15)], $urandom_range(1, 3));
      recaps = 0;
      done = 1'b0;
      while (!done) begin
        if (recaps < 1 && m_seen != 4'h0 && $urandom_range(4) == 0) begin
          do idx = $urandom_range(3); while (!m_seen[idx]);
          recaps++;
        end else begin
          do idx = $urandom_range(3); while (m_seen[idx]);
        end
        if ($urandom_range(3) == 0) glitch($urandom_range(3), $urandom_range(1, 2));
        if ($urandom_range(7) == 0) cap_bad(idx, $urandom_range(CAP_MIN, CAP_MIN + 2));
        else cap(idx, 4'($urandom_range(15)), $urandom_range(CAP_MIN, CAP_MIN + 2));
        done = (m_seen == 4'h0);
      end
    end

    blank(20);
    check("queue_drained", expq.size(), 0);
    check("final_timeout_idle", timeout_err, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
